rvfi_commit_tracker: RTL

- Parametrised commit-side RVFI bookkeeping block for the out-of-order core.
- Accepts up to NUM_CH in-order retirements per cycle from the ROB. Assigns each retirement a monotonically increasing RVFI order, registers per-channel RVFI valid/order/PC, and detects halt (branch-to-self) and commit-stall timeout.
- Replaces the single-commit order counter and hard-wired halt in the testbench top; instantiated between ROB retire ports and the rvfi interface.

---
 rtl/rvfi_commit_tracker_if.sv | 25 ++
 rtl/rvfi_commit_tracker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_tracker_if.sv
// Commit-side bus between the ROB retire ports and the RVFI tracker:
// per-channel retire strobes/PCs in, registered RVFI valid/order/PC out.
interface rvfi_commit_tracker_if #(
    parameter int NUM_CH  = 2,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) ();
    logic [NUM_CH-1:0]         commit_valid;
    logic [NUM_CH*XLEN-1:0]    commit_pc_rdata;
    logic [NUM_CH*XLEN-1:0]    commit_pc_wdata;
    logic [NUM_CH-1:0]         rvfi_valid;
    logic [NUM_CH*ORDER_W-1:0] rvfi_order;
    logic [NUM_CH*XLEN-1:0]    rvfi_pc_rdata;
    logic [NUM_CH*XLEN-1:0]    rvfi_pc_wdata;

    modport master (
        output commit_valid, commit_pc_rdata, commit_pc_wdata,
        input  rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata
    );

    modport slave (
        input  commit_valid, commit_pc_rdata, commit_pc_wdata,
        output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata
    );
endinterface

// File: rtl/rvfi_commit_tracker.sv
// Multi-channel RVFI order assignment with halt (branch-to-self) and commit-stall watchdog.
// Optional statistics counters enabled by defining RVFI_TRACKER_STATS_EN.
module rvfi_commit_tracker #(
    parameter int NUM_CH         = 2,
    parameter int XLEN           = 32,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    rvfi_commit_tracker_if.slave bus,
    output logic               halt,
    output logic               timeout,
    output logic               protocol_err,
    output logic [ORDER_W-1:0] instret
`ifdef RVFI_TRACKER_STATS_EN
    ,
    output logic [ORDER_W-1:0] cycle_cnt,
    output logic [ORDER_W-1:0] multi_commit_cnt
`endif
);
    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(HALT_REPEAT);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_TIMEOUT} state_t;

    state_t              state_reg, state_next;
    logic [ORDER_W-1:0]  order_reg, order_next;
    logic [LOOP_W-1:0]   loop_cnt_reg, loop_cnt_next;
    logic [WD_W-1:0]     wd_reg, wd_next;
    logic [NUM_CH-1:0]   prefix, accept, self_loop;
    logic [CNT_W-1:0]    accept_cnt;
    logic                halt_hit, gap, active, run_ok;

    logic [XLEN-1:0]     pc_rdata [NUM_CH];
    logic [XLEN-1:0]     pc_wdata [NUM_CH];

    logic [NUM_CH-1:0]   rvfi_valid_reg;
    logic [ORDER_W-1:0]  rvfi_order_reg [NUM_CH];
    logic [XLEN-1:0]     rvfi_pc_rdata_reg [NUM_CH];
    logic [XLEN-1:0]     rvfi_pc_wdata_reg [NUM_CH];
    logic                halt_reg, timeout_reg, protocol_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign pc_rdata[gi]  = bus.commit_pc_rdata[gi*XLEN +: XLEN];
            assign pc_wdata[gi]  = bus.commit_pc_wdata[gi*XLEN +: XLEN];
            assign self_loop[gi] = (pc_rdata[gi] == pc_wdata[gi]);
            assign bus.rvfi_order[gi*ORDER_W +: ORDER_W] = rvfi_order_reg[gi];
            assign bus.rvfi_pc_rdata[gi*XLEN +: XLEN]    = rvfi_pc_rdata_reg[gi];
            assign bus.rvfi_pc_wdata[gi*XLEN +: XLEN]    = rvfi_pc_wdata_reg[gi];
        end
    endgenerate

    assign bus.rvfi_valid = rvfi_valid_reg;
    assign halt           = halt_reg;
    assign timeout        = timeout_reg;
    assign protocol_err   = protocol_err_reg;
    assign instret        = order_reg;

    always_comb begin
        prefix = '0;
        run_ok = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            run_ok    = run_ok & bus.commit_valid[i];
            prefix[i] = run_ok;
        end
        gap    = (bus.commit_valid != prefix);
        active = (state_reg == ST_IDLE) || (state_reg == ST_RUN);

        // Walk channels oldest-first; the commit completing the self-loop run
        // is the last one accepted this cycle.
        accept        = '0;
        accept_cnt    = '0;
        loop_cnt_next = loop_cnt_reg;
        halt_hit      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active && prefix[i] && !halt_hit) begin
                accept[i]  = 1'b1;
                accept_cnt = accept_cnt + CNT_W'(1);
                if (self_loop[i]) begin
                    loop_cnt_next = loop_cnt_next + LOOP_W'(1);
                    if (loop_cnt_next == LOOP_MAX) halt_hit = 1'b1;
                end else begin
                    loop_cnt_next = '0;
                end
            end
        end

        order_next = order_reg + ORDER_W'(accept_cnt);

        if (accept_cnt != '0)   wd_next = '0;
        else if (wd_reg == WD_MAX) wd_next = wd_reg;
        else                       wd_next = wd_reg + WD_W'(1);

        state_next = state_reg;
        if (active) begin
            if (halt_hit)
                state_next = ST_HALT;
            else if (state_reg == ST_RUN && wd_next == WD_MAX)
                state_next = ST_TIMEOUT;
            else if (accept_cnt != '0)
                state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            order_reg        <= '0;
            loop_cnt_reg     <= '0;
            wd_reg           <= '0;
            halt_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
            protocol_err_reg <= 1'b0;
            rvfi_valid_reg   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rvfi_order_reg[i]    <= '0;
                rvfi_pc_rdata_reg[i] <= '0;
                rvfi_pc_wdata_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            order_reg    <= order_next;
            loop_cnt_reg <= loop_cnt_next;
            // Watchdog is disarmed outside RUN
            wd_reg       <= (state_reg == ST_RUN) ? wd_next : '0;
            halt_reg     <= (state_next == ST_HALT);
            timeout_reg  <= (state_next == ST_TIMEOUT);
            if (gap) protocol_err_reg <= 1'b1;
            rvfi_valid_reg <= accept;
            for (int i = 0; i < NUM_CH; i++) begin
                rvfi_order_reg[i]    <= accept[i] ? order_reg + ORDER_W'(i) : '0;
                rvfi_pc_rdata_reg[i] <= accept[i] ? pc_rdata[i] : '0;
                rvfi_pc_wdata_reg[i] <= accept[i] ? pc_wdata[i] : '0;
            end
        end
    end

`ifdef RVFI_TRACKER_STATS_EN
    logic [ORDER_W-1:0] cycle_cnt_reg, multi_commit_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_reg        <= '0;
            multi_commit_cnt_reg <= '0;
        end else begin
            if (active) cycle_cnt_reg <= cycle_cnt_reg + ORDER_W'(1);
            if (accept_cnt >= CNT_W'(2)) multi_commit_cnt_reg <= multi_commit_cnt_reg + ORDER_W'(1);
        end
    end

    assign cycle_cnt        = cycle_cnt_reg;
    assign multi_commit_cnt = multi_commit_cnt_reg;
`endif
endmodule
